// File: rtl/imem_load_responder_if.sv
// Fetch-side imem load bus between the fetch unit (master) and the
// instruction memory responder (slave). err exists only with IMEM_LOAD_ERR_EN.
interface imem_load_responder_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] addr;
    logic                  en;
    logic [31:0]           insn;
    logic                  busy;
    logic                  rdy;
`ifdef IMEM_LOAD_ERR_EN
    logic                  err;
`endif

    modport master (
        output addr,
        output en,
        input  insn,
        input  busy,
`ifdef IMEM_LOAD_ERR_EN
        input  err,
`endif
        input  rdy
    );

    modport slave (
        input  addr,
        input  en,
        output insn,
        output busy,
`ifdef IMEM_LOAD_ERR_EN
        output err,
`endif
        output rdy
    );
endinterface

// File: rtl/imem_load_responder.sv
// Instruction memory responder: fixed-latency word fetch with flush, and a
// program-load write port into a word-addressed SRAM array.
// Ports: clk, rst (sync, active-high), imem_load (slave: addr, en, insn,
// busy, rdy[, err]), flush_i, prog_we_i, prog_addr_i, prog_data_i.
// Option: define IMEM_LOAD_ERR_EN to add imem_load.err (misaligned or
// out-of-range fetch indication, pulsed with rdy).
module imem_load_responder #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_load_responder_if.slave  imem_load,
    input  logic                  flush_i,
    input  logic                  prog_we_i,
    input  logic [DATA_WIDTH-1:0] prog_addr_i,
    input  logic [31:0]           prog_data_i
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [31:0]       data_q;
    logic [31:0]       mem [DEPTH];

    logic              accept;
    logic              f_rng;
    logic              p_rng;
    logic [IDX_W-1:0]  f_idx;
    logic [IDX_W-1:0]  p_idx;
    logic [31:0]       rd_word;
    logic              unused_ok;

    // Anything set above the word index puts the address outside the array.
    assign f_rng   = (imem_load.addr >> (IDX_W + 2)) == '0;
    assign p_rng   = (prog_addr_i >> (IDX_W + 2)) == '0;
    assign f_idx   = imem_load.addr[IDX_W+1:2];
    assign p_idx   = prog_addr_i[IDX_W+1:2];
    assign rd_word = f_rng ? mem[f_idx] : NOP;

    assign accept = (state == IDLE) && imem_load.en && !flush_i;

    assign imem_load.busy = (state != IDLE);
    assign imem_load.rdy  = (state == RESP) && !flush_i;

    assign unused_ok = ^{imem_load.addr[1:0], prog_addr_i[1:0]};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_n   = CNT_W'(LATENCY - 1);
                    state_n = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    state_n = RESP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            data_q         <= '0;
            imem_load.insn <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                data_q <= rd_word;
            end
            // With LATENCY==1 RESP is entered on the accept edge itself,
            // before data_q holds the word, so take it straight from the array.
            if (accept && (LATENCY == 1)) begin
                imem_load.insn <= rd_word;
            end else if ((state == WAIT) && (state_n == RESP)) begin
                imem_load.insn <= data_q;
            end
        end
    end

    // Array is not reset; NBA ordering gives read-before-write on collision.
    always_ff @(posedge clk) begin
        if (prog_we_i && p_rng) begin
            mem[p_idx] <= prog_data_i;
        end
    end

`ifdef IMEM_LOAD_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= !f_rng || (imem_load.addr[1:0] != 2'b00);
        end
    end

    assign imem_load.err = (state == RESP) && !flush_i && err_q;
`endif

endmodule

// File: tb/tb_imem_load_responder.sv
// Self-checking bench for imem_load_responder: directed scenarios plus a
// randomized run against a cycle-count reference model.
module tb_imem_load_responder;

    localparam int DW    = 64;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          prog_we_i;
    logic [DW-1:0] prog_addr_i;
    logic [31:0]   prog_data_i;

    int errs = 0;
    int checks = 0;

    logic [31:0] mdl [DEPTH];

    imem_load_responder_if #(.DATA_WIDTH(DW)) bus ();

    imem_load_responder #(
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_load(bus),
        .flush_i(flush_i),
        .prog_we_i(prog_we_i),
        .prog_addr_i(prog_addr_i),
        .prog_data_i(prog_data_i)
    );

    always #5 clk = ~clk;

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.en = 1'b0;
        flush_i = 1'b0;
        prog_we_i = 1'b0;
        repeat (n) to_next();
    endtask

    task automatic load_word(input int idx, input logic [31:0] d);
        prog_we_i = 1'b1;
        prog_addr_i = DW'(idx) * 4;
        prog_data_i = d;
        to_next();
        prog_we_i = 1'b0;
        mdl[idx] = d;
    endtask

    task automatic fill_all();
        for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.addr = 64'h10;
        for (int k = 0; k < 2; k++) begin
            to_neg();
            checks++;
            if (bus.busy !== 1'b0 || bus.rdy !== 1'b0 || bus.insn !== 32'h0) begin
                errs++;
                $display("FAIL reset_state cyc%0d: busy=%b rdy=%b insn=%h, want 0 0 0",
                         k, bus.busy, bus.rdy, bus.insn);
            end
            to_next();
        end
        rst = 1'b0;
        bus.en = 1'b0;
        to_neg();
        checks++;
        if (bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_no_accept: busy=%b, want 0", bus.busy);
        end
        to_next();
    endtask

    task automatic test_single();
        logic e_busy, e_rdy;
        load_word(4, 32'h00A00093);
        bus.en = 1'b1;
        bus.addr = 64'h10;
        to_next();
        bus.en = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            to_neg();
            e_busy = (k <= LAT);
            e_rdy = (k == LAT);
            checks++;
            if (bus.busy !== e_busy || bus.rdy !== e_rdy) begin
                errs++;
                $display("FAIL single T+%0d: busy=%b rdy=%b, want %b %b",
                         k, bus.busy, bus.rdy, e_busy, e_rdy);
            end
            if (e_rdy) begin
                checks++;
                if (bus.insn !== 32'h00A00093) begin
                    errs++;
                    $display("FAIL single_insn: got %h want 00a00093", bus.insn);
                end
            end
            to_next();
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic [31:0] want;
        load_word(0, 32'h11);
        load_word(1, 32'h22);
        for (int k = 0; k < 8; k++) begin
            bus.en = (k < 6);
            bus.addr = (k == 0) ? 64'h0 : 64'h4;
            to_neg();
            if (bus.rdy === 1'b1) pulses++;
            if (k == 2 || k == 5) begin
                want = (k == 2) ? 32'h11 : 32'h22;
                checks++;
                if (bus.rdy !== 1'b1 || bus.insn !== want) begin
                    errs++;
                    $display("FAIL b2b T+%0d: rdy=%b insn=%h, want 1 %h",
                             k, bus.rdy, bus.insn, want);
                end
            end
            to_next();
        end
        checks++;
        if (pulses != 2) begin
            errs++;
            $display("FAIL b2b_pulses: got %0d want 2", pulses);
        end
        idle(1);
    endtask

    task automatic test_flush();
        bus.en = 1'b1;
        bus.addr = 64'h8;
        to_next();
        bus.en = 1'b0;
        flush_i = 1'b1;
        to_neg();
        checks++;
        if (bus.busy !== 1'b1 || bus.rdy !== 1'b0) begin
            errs++;
            $display("FAIL flush_T1: busy=%b rdy=%b, want 1 0", bus.busy, bus.rdy);
        end
        to_next();
        flush_i = 1'b0;
        bus.en = 1'b1;
        bus.addr = 64'h10;
        to_neg();
        checks++;
        if (bus.busy !== 1'b0 || bus.rdy !== 1'b0) begin
            errs++;
            $display("FAIL flush_T2: busy=%b rdy=%b, want 0 0", bus.busy, bus.rdy);
        end
        to_next();
        bus.en = 1'b0;
        to_next();
        to_neg();
        checks++;
        if (bus.rdy !== 1'b1 || bus.insn !== mdl[4]) begin
            errs++;
            $display("FAIL flush_refetch: rdy=%b insn=%h, want 1 %h",
                     bus.rdy, bus.insn, mdl[4]);
        end
        to_next();
        idle(1);
    endtask

    task automatic test_collision();
        load_word(3, 32'hAAAA0000);
        bus.en = 1'b1;
        bus.addr = 64'hC;
        prog_we_i = 1'b1;
        prog_addr_i = 64'hC;
        prog_data_i = 32'hBBBB0000;
        to_next();
        mdl[3] = 32'hBBBB0000;
        prog_we_i = 1'b0;
        bus.en = 1'b0;
        to_next();
        to_neg();
        checks++;
        if (bus.rdy !== 1'b1 || bus.insn !== 32'hAAAA0000) begin
            errs++;
            $display("FAIL collision_old: rdy=%b insn=%h, want 1 aaaa0000",
                     bus.rdy, bus.insn);
        end
        to_next();
        bus.en = 1'b1;
        to_next();
        bus.en = 1'b0;
        to_next();
        to_neg();
        checks++;
        if (bus.rdy !== 1'b1 || bus.insn !== 32'hBBBB0000) begin
            errs++;
            $display("FAIL collision_new: rdy=%b insn=%h, want 1 bbbb0000",
                     bus.rdy, bus.insn);
        end
        to_next();
        idle(1);
    endtask

    task automatic fetch_check(input logic [DW-1:0] a, input logic [31:0] want,
                               input logic want_err, input string nm);
        bus.en = 1'b1;
        bus.addr = a;
        to_next();
        bus.en = 1'b0;
        to_next();
        to_neg();
        checks++;
        if (bus.rdy !== 1'b1 || bus.insn !== want) begin
            errs++;
            $display("FAIL %s: rdy=%b insn=%h, want 1 %h", nm, bus.rdy, bus.insn, want);
        end
`ifdef IMEM_LOAD_ERR_EN
        checks++;
        if (bus.err !== want_err) begin
            errs++;
            $display("FAIL %s_err: err=%b want %b", nm, bus.err, want_err);
        end
`else
        if (want_err === 1'bx) $display("note: unknown err expectation");
`endif
        to_next();
        idle(1);
    endtask

    task automatic test_out_of_range();
        fetch_check(DW'(DEPTH) * 4, NOP, 1'b1, "oor_top");
        fetch_check(64'h1 << 40, NOP, 1'b1, "oor_high");
        fetch_check(64'h6, mdl[1], 1'b1, "misaligned");
        fetch_check(64'h4, mdl[1], 1'b0, "aligned");
    endtask

    task automatic test_random();
        bit          inflight = 0;
        int          t0 = 0;
        logic [31:0] exp_d = '0;
        logic        exp_e = 1'b0;
        logic        e_rdy;
        int          sel;
        for (int n = 0; n < 600; n++) begin
            bus.en = (n < 596) && ($urandom_range(0, 3) != 0);
            flush_i = (n < 596) && ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0) bus.addr = DW'(DEPTH) * 4 + DW'($urandom_range(0, 15));
            else if (sel == 1) bus.addr = 64'h1 << $urandom_range(13, 63);
            else bus.addr = DW'($urandom_range(0, 31));
            prog_we_i = ($urandom_range(0, 2) == 0);
            prog_addr_i = ($urandom_range(0, 7) == 0) ? DW'(DEPTH) * 4
                                                      : DW'($urandom_range(0, 31));
            prog_data_i = $urandom;
            to_neg();
            e_rdy = inflight && (n - t0 == LAT) && !flush_i;
            checks++;
            if (bus.busy !== inflight || bus.rdy !== e_rdy) begin
                errs++;
                $display("FAIL rand n=%0d: busy=%b rdy=%b, want %b %b",
                         n, bus.busy, bus.rdy, inflight, e_rdy);
            end
            if (e_rdy) begin
                checks++;
                if (bus.insn !== exp_d) begin
                    errs++;
                    $display("FAIL rand_insn n=%0d: got %h want %h", n, bus.insn, exp_d);
                end
`ifdef IMEM_LOAD_ERR_EN
                checks++;
                if (bus.err !== exp_e) begin
                    errs++;
                    $display("FAIL rand_err n=%0d: got %b want %b", n, bus.err, exp_e);
                end
`endif
            end
            if (inflight) begin
                if (flush_i || (n - t0 == LAT)) inflight = 0;
            end else if (bus.en && !flush_i) begin
                inflight = 1;
                t0 = n;
                if (bus.addr < DW'(DEPTH) * 4) begin
                    exp_d = mdl[int'(bus.addr) / 4];
                    exp_e = (bus.addr % 4) != 0;
                end else begin
                    exp_d = NOP;
                    exp_e = 1'b1;
                end
            end
            if (prog_we_i && prog_addr_i < DW'(DEPTH) * 4)
                mdl[int'(prog_addr_i) / 4] = prog_data_i;
            to_next();
        end
        idle(2);
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.addr = '0;
        flush_i = 1'b0;
        prog_we_i = 1'b0;
        prog_addr_i = '0;
        prog_data_i = '0;
        to_next();
        test_reset();
        fill_all();
        test_single();
        test_back_to_back();
        test_flush();
        test_collision();
        test_out_of_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
